// File: rtl/alu.sv
// ALU with a combinational result path and a one-cycle registered capture stage.
// Optional feature macro: ALU_OVF_EN enables signed-overflow detection on ovf_q.
// Without ALU_OVF_EN, ovf_q is tied to 0.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [2:0]       alu_ctrl,
  input  logic             in_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic [WIDTH-1:0] res_q,
  output logic             zero_q,
  output logic             ovf_q,
  output logic             out_valid
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  logic             sub_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             adder_ovf;
  logic             slt_bit;
  logic             sltu_bit;
  logic             ovf_d;

  // Shared adder: SUB and both compares run A + ~B + 1 on the same datapath.
  always_comb begin
    sub_op    = (alu_ctrl == OP_SUB) || (alu_ctrl == OP_SLT) || (alu_ctrl == OP_SLTU);
    b_eff     = sub_op ? ~srcb : srcb;
    sum_full  = {1'b0, srca} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
    sum       = sum_full[WIDTH-1:0];
    carry_out = sum_full[WIDTH];
    // Signed overflow: operands (A and effective B) agree in sign but sum does not.
    adder_ovf = (srca[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
    // Sign of the true difference is the raw sign corrected by overflow.
    slt_bit   = sum[WIDTH-1] ^ adder_ovf;
    // No carry out of A + ~B + 1 means a borrow, i.e. A < B unsigned.
    sltu_bit  = ~carry_out;
  end

  // Result select and zero flag, purely from the current inputs.
  always_comb begin
    alu_out = '0;
    unique case (alu_ctrl)
      OP_AND:  alu_out = srca & srcb;
      OP_OR:   alu_out = srca | srcb;
      OP_ADD:  alu_out = sum;
      OP_XOR:  alu_out = srca ^ srcb;
      OP_NOR:  alu_out = ~(srca | srcb);
      OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, sltu_bit};
      OP_SUB:  alu_out = sum;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, slt_bit};
      default: alu_out = '0;
    endcase
    zero = (alu_out == '0);
  end

  // Overflow flag is only meaningful for ADD and SUB.
  always_comb begin
`ifdef ALU_OVF_EN
    ovf_d = adder_ovf && ((alu_ctrl == OP_ADD) || (alu_ctrl == OP_SUB));
`else
    ovf_d = 1'b0;
`endif
  end

  // Capture stage: one result per valid cycle, results held while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res_q  <= alu_out;
        zero_q <= zero;
        ovf_q  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner vectors, reset behaviour and
// randomized traffic compared against an arithmetic reference model.
module tb_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] srca, srcb;
  logic [2:0]   alu_ctrl;
  logic         in_valid;
  logic [W-1:0] alu_out, res_q;
  logic         zero, zero_q, ovf_q, out_valid;

  int errors = 0;
  int checks = 0;

  // Expected registered state
  logic [W-1:0] exp_res;
  logic         exp_zero, exp_ovf, exp_valid;

  always #5 clk = ~clk;

  alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .srca(srca), .srcb(srcb), .alu_ctrl(alu_ctrl),
    .in_valid(in_valid), .alu_out(alu_out), .zero(zero), .res_q(res_q),
    .zero_q(zero_q), .ovf_q(ovf_q), .out_valid(out_valid)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return a ^ b;
      3'd4: return ~(a | b);
      3'd5: return (a < b) ? 1 : 0;
      3'd6: return a - b;
      default: return ($signed(a) < $signed(b)) ? 1 : 0;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [2:0] op);
    longint sa, sb, r;
    logic   ovf, en;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 3'd2)      r = sa + sb;
    else if (op == 3'd6) r = sa - sb;
    else                 r = 0;
    ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifdef ALU_OVF_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en & ovf;
  endfunction

  task automatic check_regs(input string tag);
    check({tag, " res_q"},     res_q,     exp_res);
    check({tag, " zero_q"},    zero_q,    exp_zero);
    check({tag, " ovf_q"},     ovf_q,     exp_ovf);
    check({tag, " out_valid"}, out_valid, exp_valid);
  endtask

  // One transaction: drive between edges, check comb outputs, clock, check registers.
  task automatic step(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op, input logic v);
    logic [W-1:0] r;
    @(negedge clk);
    srca = a; srcb = b; alu_ctrl = op; in_valid = v;
    #1;
    r = model_res(a, b, op);
    check({tag, " alu_out"}, alu_out, r);
    check({tag, " zero"},    zero,    (r == '0));
    @(posedge clk);
    #1;
    if (v) begin
      exp_res  = r;
      exp_zero = (r == '0);
      exp_ovf  = model_ovf(a, b, op);
    end
    exp_valid = v;
    check_regs(tag);
    $display("txn %-10s op=%0d a=%h b=%h v=%0b -> res_q=%h zq=%0b oq=%0b ov=%0b",
             tag, op, a, b, v, res_q, zero_q, ovf_q, out_valid);
  endtask

  // Directed vector with a literal expected result from the datasheet examples.
  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input logic [W-1:0] want);
    @(negedge clk);
    srca = a; srcb = b; alu_ctrl = op; in_valid = 1'b0;
    #1;
    check({tag, " const"}, alu_out, want);
    step(tag, a, b, op, 1'b1);
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] sp [5];
    sp[0] = 32'h0000_0000; sp[1] = 32'h0000_0001; sp[2] = 32'h7FFF_FFFF;
    sp[3] = 32'h8000_0000; sp[4] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    rst_n = 1'b0; srca = '0; srcb = '0; alu_ctrl = 3'd0; in_valid = 1'b1;
    exp_res = '0; exp_zero = 1'b0; exp_ovf = 1'b0; exp_valid = 1'b0;
    #12;
    check_regs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    directed("add10_15",  32'd10, 32'd15, 3'b010, 32'd25);
    directed("sub15_10",  32'd15, 32'd10, 3'b110, 32'd5);
    directed("sub7_7",    32'd7,  32'd7,  3'b110, 32'd0);
    check("sub7_7 zq lit", zero_q, 1'b1);
    directed("add_ovf",   32'h7FFF_FFFF, 32'd1, 3'b010, 32'h8000_0000);
    directed("slt_m1_1",  32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1);
    directed("sltu_m1_1", 32'hFFFF_FFFF, 32'd1, 3'b101, 32'd0);
    directed("slt_min_1", 32'h8000_0000, 32'd1, 3'b111, 32'd1);
    directed("slt_1_min", 32'd1, 32'h8000_0000, 3'b111, 32'd0);
    directed("sub_ovf",   32'h8000_0000, 32'd1, 3'b110, 32'h7FFF_FFFF);
    directed("and",       32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000);
    directed("or",        32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 32'hFFF0_FFF0);
    directed("xor",       32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011, 32'h0FF0_0FF0);
    directed("nor",       32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 32'h000F_000F);

    // Asynchronous reset between edges clears registers without a clock.
    step("pre_rst", 32'd10, 32'd15, 3'b010, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_res = '0; exp_zero = 1'b0; exp_ovf = 1'b0; exp_valid = 1'b0;
    check_regs("async_rst");
    srca = 32'd3; srcb = 32'd4; alu_ctrl = 3'b010; in_valid = 1'b1;
    #1 check("rst comb", alu_out, 32'd7);
    @(posedge clk);
    #1 check_regs("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 32'd100, 32'd1, 3'b110, 1'b1);
    step("idle", 32'd5, 32'd5, 3'b011, 1'b0);

    // Randomized traffic, including back-to-back valid cycles.
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] a, b;
      a = pick_operand();
      b = ($urandom_range(0, 9) == 0) ? a : pick_operand();
      step("rand", a, b, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits; all data ports and arithmetic use WIDTH.
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all registered outputs.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 srca  input  WIDTH  operand A.
REQ-006 srcb  input  WIDTH  operand B.
REQ-007 alu_ctrl  input  3  operation select.
REQ-008 in_valid  input  1  qualifies srca/srcb/alu_ctrl for capture.
REQ-009 alu_out  output  WIDTH  combinational result of the current inputs.
REQ-010 zero  output  1  combinational; 1 when alu_out == 0.
REQ-011 res_q  output  WIDTH  registered result.
REQ-012 zero_q  output  1  registered zero flag.
REQ-013 ovf_q  output  1  registered signed-overflow flag.
REQ-014 out_valid  output  1  registered; marks res_q/zero_q/ovf_q as valid.

Function
REQ-015 alu_ctrl decode: 000 AND; 001 OR; 010 ADD (A+B); 011 XOR; 100 NOR; 101 SLTU; 110 SUB (A-B); 111 SLT.
REQ-016 ADD and SUB shall wrap modulo 2^WIDTH; carry/borrow out is discarded from the result.
REQ-017 SUB shall be computed as A + ~B + 1 on the same adder used for ADD.
REQ-018 SLT shall output 1 (zero-extended to WIDTH) when A < B as two's-complement signed values, else 0; it shall be correct even when A-B overflows.
REQ-019 SLTU shall output 1 (zero-extended) when A < B unsigned, else 0.
REQ-020 alu_out and zero shall depend only on srca, srcb, alu_ctrl (no clock, no reset dependence) and settle within the same delta cycle.
REQ-021 Overflow (internal): ADD sets it when A and B have equal sign and sum sign differs; SUB sets it when A and B differ in sign and difference sign differs from A; all other operations yield 0.
REQ-022 On a rising clk edge with in_valid=1: res_q<=alu_out, zero_q<=zero, ovf_q<=overflow, out_valid<=1; latency exactly one cycle.
REQ-023 On a rising clk edge with in_valid=0: out_valid<=0; res_q, zero_q, ovf_q hold previous values.
REQ-024 Back-to-back in_valid=1 cycles shall produce one registered result per cycle with no bubbles; no back-pressure exists.

Reset
REQ-025 rst_n=0 shall immediately (without clk) force res_q=0, zero_q=0, ovf_q=0, out_valid=0.
REQ-026 While rst_n=0, in_valid is ignored; alu_out and zero remain functional.
REQ-027 First capture shall occur on the first rising clk edge after rst_n deasserts with in_valid=1; a reset asserted mid-stream discards the pending result.

Configuration
REQ-028 Macro ALU_OVF_EN: when defined, overflow detection per REQ-021 is compiled in and drives ovf_q.
REQ-029 When ALU_OVF_EN is undefined, the overflow logic is omitted, ovf_q port remains and shall be constant 0; all other behaviour is unchanged.

Verification
REQ-030 alu_ctrl=010, srca=10, srcb=15 -> alu_out=25 after 1 ns, zero=0; after one clk with in_valid=1, res_q=25, out_valid=1.
REQ-031 alu_ctrl=110, srca=15, srcb=10 -> alu_out=5; srca=srcb=7 -> alu_out=0, zero=1, zero_q=1 after capture.
REQ-032 alu_ctrl=010, srca=0x7FFFFFFF, srcb=1 -> alu_out=0x80000000, ovf_q=1 with ALU_OVF_EN, ovf_q=0 without.
REQ-033 alu_ctrl=111, srca=0xFFFFFFFF (-1), srcb=1 -> alu_out=1; alu_ctrl=101 same operands -> alu_out=0; srca=0x80000000, srcb=1, SLT -> 1.
REQ-034 Logic ops srca=0xF0F0F0F0, srcb=0xFF00FF00: AND=0xF000F000, OR=0xFFF0FFF0, XOR=0x0FF00FF0, NOR=0x000F000F.
REQ-035 Capture a result, then pulse rst_n low between edges -> res_q, zero_q, ovf_q, out_valid read 0 before next clk; in_valid=0 cycle -> out_valid=0, res_q held.
